// File: rtl/truth_table_checker_if.sv
// Bundle between the truth-table checker and the implementations under test:
// sweep control, vector drive, sampled outputs and result reporting.
interface truth_table_checker_if #(
    parameter int unsigned N_CH = 3
);
    logic                   start;
    logic [3:0]             vec_out;
    logic [N_CH-1:0]        f_in;
    logic                   busy;
    logic                   done;
    logic [16*N_CH-1:0]     table_out;
    logic [6:0]             mismatch_cnt;
    logic                   pass;
    logic                   fail_valid;
    logic [3:0]             first_fail_idx;
    logic [1:0]             first_fail_ch;

    // Stimulus/observer side: launches sweeps and feeds implementation outputs back.
    modport master (
        output start,
        output f_in,
        input  vec_out,
        input  busy,
        input  done,
        input  table_out,
        input  mismatch_cnt,
        input  pass,
        input  fail_valid,
        input  first_fail_idx,
        input  first_fail_ch
    );

    // Checker side.
    modport slave (
        input  start,
        input  f_in,
        output vec_out,
        output busy,
        output done,
        output table_out,
        output mismatch_cnt,
        output pass,
        output fail_valid,
        output first_fail_idx,
        output first_fail_ch
    );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive 16-vector sweep over N_CH parallel implementations of F(w,x,y,z);
// captures per-channel truth tables and scores them against EXPECTED.
module truth_table_checker #(
    parameter int unsigned N_CH          = 3,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h1F55
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_checker_if.slave bus
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                vec_q, vec_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [N_CH-1:0][15:0]     tbl_q, tbl_d;
    logic [6:0]                mcnt_q, mcnt_d;
    logic                      pass_q, pass_d;
    logic                      fv_q, fv_d;
    logic [3:0]                ffi_q, ffi_d;
    logic [1:0]                ffc_q, ffc_d;

    // Per-vector compare results, valid whenever vec_q is presented
    logic                      exp_bit;
    logic [2:0]                nmis;
    logic                      hit;
    logic [1:0]                hit_ch;

    always_comb begin
        exp_bit = EXPECTED[vec_q];
        nmis    = 3'd0;
        hit     = 1'b0;
        hit_ch  = 2'd0;
        // Descending scan so the lowest mismatching channel is the one kept
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (bus.f_in[CH_W'(c)] != exp_bit) begin
                nmis   = nmis + 3'd1;
                hit    = 1'b1;
                hit_ch = 2'(c);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tbl_d   = tbl_q;
        mcnt_d  = mcnt_q;
        pass_d  = pass_q;
        fv_d    = fv_q;
        ffi_d   = ffi_q;
        ffc_d   = ffc_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = DRIVE;
                    vec_d   = 4'd0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    tbl_d   = '0;
                    mcnt_d  = 7'd0;
                    pass_d  = 1'b0;
                    fv_d    = 1'b0;
                    ffi_d   = 4'd0;
                    ffc_d   = 2'd0;
                end
            end

            DRIVE: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SAMPLE: begin
                busy_d = 1'b1;
                for (int c = 0; c < N_CH; c++) begin
                    tbl_d[CH_W'(c)][vec_q] = bus.f_in[CH_W'(c)];
                end
                mcnt_d = mcnt_q + 7'(nmis);
                if (hit && !fv_q) begin
                    fv_d  = 1'b1;
                    ffi_d = vec_q;
                    ffc_d = hit_ch;
                end
                if (vec_q == 4'd15) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mcnt_d == 7'd0);
                end else begin
                    state_d = DRIVE;
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = '0;
                end
            end

            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tbl_q   <= '0;
            mcnt_q  <= 7'd0;
            pass_q  <= 1'b0;
            fv_q    <= 1'b0;
            ffi_q   <= 4'd0;
            ffc_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tbl_q   <= tbl_d;
            mcnt_q  <= mcnt_d;
            pass_q  <= pass_d;
            fv_q    <= fv_d;
            ffi_q   <= ffi_d;
            ffc_q   <= ffc_d;
        end
    end

    assign bus.vec_out        = vec_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.table_out      = tbl_q;
    assign bus.mismatch_cnt   = mcnt_q;
    assign bus.pass           = pass_q;
    assign bus.fail_valid     = fv_q;
    assign bus.first_fail_idx = ffi_q;
    assign bus.first_fail_ch  = ffc_q;

endmodule
